// File: rtl/cpu.sv
// Multi-cycle RV32I core (FETCH -> EXEC [-> MEM]) with a reset-cleared register
// file and a 16 KiB BIOS memory shared between instruction fetch and data access.

module cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : mem[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : mem[ra2];
endmodule

module cpu_bios (
    input  logic        clk,
    input  logic [11:0] addr,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [4096];
    logic [31:0] rdata_q;

    // Read-before-write: a store cycle returns the old word, which nobody consumes.
    always_ff @(posedge clk) begin
        rdata_q <= mem[addr];
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign rdata = rdata_q;
endmodule

module cpu #(
    parameter int CPU_CLOCK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic bp_enable,
    input  logic serial_in,
    output logic serial_out
);
    localparam logic [31:0] RESET_PC  = 32'h4000_0000;
    localparam logic [6:0]  OPC_LUI   = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
    localparam logic [6:0]  OPC_JAL   = 7'b1101111;
    localparam logic [6:0]  OPC_JALR  = 7'b1100111;
    localparam logic [6:0]  OPC_BR    = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP    = 7'b0110011;

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        ld_hit_q, ld_hit_d;

    logic [31:0] bios_rdata, bios_wdata;
    logic [11:0] bios_addr;
    logic [3:0]  bios_we;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rs1_val, rs2_val;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = bios_rdata;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign alt    = instr[30];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    cpu_regfile u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (rf_we),
        .wa  (rf_waddr),
        .wd  (rf_wdata)
    );

    cpu_bios u_bios (
        .clk   (clk),
        .addr  (bios_addr),
        .we    (bios_we),
        .wdata (bios_wdata),
        .rdata (bios_rdata)
    );

    logic [31:0] alu_b, alu_out;
    logic [4:0]  shamt;

    always_comb begin
        alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
        shamt   = alu_b[4:0];
        alu_out = '0;
        case (f3)
            3'd0: alu_out = (opcode == OPC_OP && alt) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1: alu_out = rs1_val << shamt;
            3'd2: alu_out = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            3'd3: alu_out = {31'h0, rs1_val < alu_b};
            3'd4: alu_out = rs1_val ^ alu_b;
            3'd5: alu_out = alt ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'd6: alu_out = rs1_val | alu_b;
            3'd7: alu_out = rs1_val & alu_b;
            default: alu_out = '0;
        endcase
    end

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'd0: br_taken = (rs1_val == rs2_val);
            3'd1: br_taken = (rs1_val != rs2_val);
            3'd4: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'd5: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6: br_taken = (rs1_val <  rs2_val);
            3'd7: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    logic [31:0] daddr, jalr_sum;
    logic        d_hit;
    logic [3:0]  st_be;

    assign daddr    = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign d_hit    = (daddr[31:14] == 18'h10000);
    assign jalr_sum = rs1_val + imm_i;

    // Narrow stores replicate their data across the word; the lane enables pick the target.
    always_comb begin
        st_be      = 4'b0000;
        bios_wdata = rs2_val;
        case (f3)
            3'd0: begin
                st_be      = 4'b0001 << daddr[1:0];
                bios_wdata = {4{rs2_val[7:0]}};
            end
            3'd1: begin
                st_be      = daddr[1] ? 4'b1100 : 4'b0011;
                bios_wdata = {2{rs2_val[15:0]}};
            end
            3'd2: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    logic [31:0] ld_word, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_word = ld_hit_q ? bios_rdata : 32'h0;
        ld_byte = ld_word[{ld_off_q, 3'b000} +: 8];
        ld_half = ld_off_q[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_f3_q)
            3'd0: ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1: ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4: ld_ext = {24'h0, ld_byte};
            3'd5: ld_ext = {16'h0, ld_half};
            default: ld_ext = ld_word;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;
        ld_hit_d  = ld_hit_q;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = '0;
        bios_we   = 4'b0000;
        bios_addr = pc_q[13:2];
        case (state_q)
            FETCH: state_d = EXEC;
            EXEC: begin
                bios_addr = daddr[13:2];
                state_d   = FETCH;
                pc_d      = pc_q + 32'd4;
                case (opcode)
                    OPC_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_u;
                    end
                    OPC_AUIPC: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + imm_u;
                    end
                    OPC_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + 32'd4;
                        pc_d     = pc_q + imm_j;
                    end
                    OPC_JALR: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + 32'd4;
                        pc_d     = {jalr_sum[31:1], 1'b0};
                    end
                    OPC_BR: if (br_taken) pc_d = pc_q + imm_b;
                    OPC_LOAD: begin
                        state_d  = MEM;
                        pc_d     = pc_q;
                        ld_rd_d  = rd;
                        ld_f3_d  = f3;
                        ld_off_d = daddr[1:0];
                        ld_hit_d = d_hit;
                    end
                    OPC_STORE: bios_we = d_hit ? st_be : 4'b0000;
                    OPC_OPIMM, OPC_OP: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_out;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                rf_we    = 1'b1;
                rf_waddr = ld_rd_q;
                rf_wdata = ld_ext;
                pc_d     = pc_q + 32'd4;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ld_rd_q  <= '0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
            ld_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ld_rd_q  <= ld_rd_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
            ld_hit_q <= ld_hit_d;
        end
    end

    assign serial_out = 1'b1;

    logic unused_inputs;
    assign unused_inputs = bp_enable ^ serial_in ^ jalr_sum[0] ^ (CPU_CLOCK_FREQ == 0);
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: an ISA-level interpreter predicts every register write (value and
// retire cycle); a monitor on the writeback port checks them in order.

module tb_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bp_enable = 1'b0;
  logic serial_in = 1'b1;
  logic serial_out;

  always #5 clk = ~clk;

  cpu dut (
    .clk        (clk),
    .rst        (rst),
    .bp_enable  (bp_enable),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [52:0] exp_q[$];  // {retire_cycle[15:0], rd[4:0], value[31:0]}
  logic [31:0] prog[$];
  logic [31:0] m_mem[4096];
  logic [31:0] m_reg[32];
  int tb_cyc = 0;

  localparam logic [31:0] HALT = 32'h0000006F;  // jal x0,0

  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  // Monitor: every non-x0 writeback must match the head of the expected queue.
  always @(negedge clk) begin
    logic [52:0] e;
    if (!rst && dut.rf_we && dut.rf_waddr != 5'd0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got x%0d=%h at cycle %0d, required no write",
                 dut.rf_waddr, dut.rf_wdata, tb_cyc + 1);
      end else begin
        e = exp_q.pop_front();
        if (dut.rf_waddr != e[36:32] || dut.rf_wdata != e[31:0] || (tb_cyc + 1) != int'(e[52:37])) begin
          n_fail++;
          $display("FAIL wb: got x%0d=%h at cycle %0d, required x%0d=%h at cycle %0d",
                   dut.rf_waddr, dut.rf_wdata, tb_cyc + 1, e[36:32], e[31:0], e[52:37]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] e_i(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [2:0] f3, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_s(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_b(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] e_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return e_i(7'h13, rd, 3'd0, rs1, imm);
  endfunction

  // ---------------- reference model (byte-addressed ISA interpreter) ----------------
  function automatic bit in_bios(input logic [31:0] a);
    return a >= 32'h4000_0000 && a <= 32'h4000_3FFF;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int nb, input bit sgn);
    logic [31:0] base, ba, r;
    logic [31:0] w;
    logic [7:0]  bt;
    base = a & ~(32'(nb) - 32'd1);
    r = 0;
    for (int k = 0; k < nb; k++) begin
      ba = base + 32'(k);
      w  = in_bios(ba) ? m_mem[ba[13:2]] : 32'h0;
      bt = 8'(w >> (8 * ba[1:0]));
      r  = r | (32'(bt) << (8 * k));
    end
    if (sgn && nb == 1) r = {{24{r[7]}}, r[7:0]};
    if (sgn && nb == 2) r = {{16{r[15]}}, r[15:0]};
    return r;
  endfunction

  task automatic m_store(input logic [31:0] a, input int nb, input logic [31:0] d);
    logic [31:0] base, ba;
    base = a & ~(32'(nb) - 32'd1);
    for (int k = 0; k < nb; k++) begin
      ba = base + 32'(k);
      if (in_bios(ba)) m_mem[ba[13:2]][8*ba[1:0] +: 8] = d[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                        input bit alt, input bit is_r);
    case (f3)
      3'd0: return (is_r && alt) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_run();
    logic [31:0] pc, npc, ins, a, b, r, ii, is, ib, iu, ij;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit wr, tk;
    int cyc, lat;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    pc = 32'h4000_0000;
    cyc = 0;
    for (int step = 0; step < 4000; step++) begin
      ins = m_mem[pc[13:2]];
      if (ins == HALT) break;
      rd = ins[11:7]; f3 = ins[14:12];
      a  = m_reg[ins[19:15]]; b = m_reg[ins[24:20]];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu = {ins[31:12], 12'h0};
      ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      npc = pc + 4; wr = 0; lat = 2; r = 0;
      case (ins[6:0])
        7'h37: begin r = iu; wr = 1; end
        7'h17: begin r = pc + iu; wr = 1; end
        7'h6F: begin r = pc + 4; wr = 1; npc = pc + ij; end
        7'h67: begin r = pc + 4; wr = 1; npc = (a + ii) & ~32'd1; end
        7'h63: begin
          case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 0;
          endcase
          if (tk) npc = pc + ib;
        end
        7'h03: begin
          lat = 3; wr = 1;
          r = m_load(a + ii, (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4, !f3[2]);
        end
        7'h23: if (f3 <= 3'd2) m_store(a + is, (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4, b);
        7'h13: begin r = m_alu(f3, a, ii, ins[30], 0); wr = 1; end
        7'h33: begin r = m_alu(f3, a, b, ins[30], 1); wr = 1; end
        default: ;
      endcase
      cyc += lat;
      if (wr && rd != 0) begin
        m_reg[rd] = r;
        exp_q.push_back({16'(cyc), rd, r});
      end
      pc = npc;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_prog(input bit rand_data);
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) begin
      w = 0;
      if (i < prog.size()) w = prog[i];
      else if (rand_data && i >= 12'h400 && i < 12'h410) w = $urandom;
      m_mem[i] = w;
      dut.u_bios.mem[i] = w;
    end
  endtask

  task automatic check_reset_state(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (dut.u_rf.mem[i] !== 32'h0) bad++;
    chk({tag, "_regs_zero"}, 32'(bad), 32'd0);
    chk({tag, "_serial_out"}, {31'h0, serial_out}, 32'd1);
  endtask

  task automatic start_prog(input bit rand_data, input string tag);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    load_prog(rand_data);
    model_run();
    check_reset_state(tag);
    rst = 1'b0;
  endtask

  task automatic finish_prog(input string tag);
    int guard = 0;
    int bad = 0;
    int first = -1;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d writes still pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) if (dut.u_rf.mem[i] !== m_reg[i]) begin bad++; if (first < 0) first = i; end
    if (first >= 0) $display("FAIL %s_reg x%0d: got %h, required %h", tag, first, dut.u_rf.mem[first], m_reg[first]);
    chk({tag, "_reg_mismatches"}, 32'(bad), 32'd0);
    bad = 0;
    for (int i = 12'h400; i < 12'h410; i++) if (dut.u_bios.mem[i] !== m_mem[i]) bad++;
    chk({tag, "_data_mismatches"}, 32'(bad), 32'd0);
  endtask

  function automatic logic [4:0] rreg(input int lo, input int hi);
    return 5'($urandom_range(hi, lo));
  endfunction

  task automatic gen_random_prog();
    logic [2:0] f3;
    logic [31:0] imm;
    int kind;
    int n = 40;
    logic [2:0] br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    prog.delete();
    prog.push_back(e_u(7'h37, 5'd31, 20'h40001));
    prog.push_back(e_u(7'h37, 5'd30, 20'h50000));
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(9, 0);
      if (kind == 9 && i == n - 1) kind = 0;
      case (kind)
        0, 1, 2, 3: begin
          f3 = 3'($urandom_range(7, 0));
          imm = $urandom;
          if (f3 == 3'd1) imm = 32'($urandom_range(31, 0));
          if (f3 == 3'd5) imm = 32'($urandom_range(31, 0)) | ($urandom_range(1, 0) ? 32'h400 : 32'h0);
          prog.push_back(e_i(7'h13, rreg(1, 29), f3, rreg(0, 31), imm));
        end
        4, 5: begin
          f3 = 3'($urandom_range(7, 0));
          prog.push_back(e_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(1, 0) == 1) ? 7'h20 : 7'h00,
                             rreg(0, 31), rreg(0, 31), f3, rreg(1, 29)));
        end
        6: prog.push_back(e_u(7'h37, rreg(1, 29), 20'($urandom)));
        7: prog.push_back(e_s(3'($urandom_range(2, 0)), ($urandom_range(7, 0) == 0) ? 5'd30 : 5'd31,
                              rreg(0, 29), 32'($urandom_range(63, 0))));
        8: prog.push_back(e_i(7'h03, rreg(1, 29), ld_f3[$urandom_range(4, 0)],
                              ($urandom_range(7, 0) == 0) ? 5'd30 : 5'd31, 32'($urandom_range(63, 0))));
        default: prog.push_back(e_b(br_f3[$urandom_range(5, 0)], rreg(0, 31), rreg(0, 31), 32'd8));
      endcase
    end
    prog.push_back(HALT);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Program 1: basic add, then a one-cycle reset mid-program and a full rerun.
    prog = '{addi(1, 0, 100), addi(2, 0, 200), e_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1), addi(20, 0, 1), HALT};
    start_prog(0, "p1");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("p1_midrst");
    exp_q.delete();
    model_run();
    rst = 1'b0;
    finish_prog("p1");
    chk("p1_x20", dut.u_rf.mem[20], 32'd1);
    chk("p1_x1", dut.u_rf.mem[1], 32'd300);

    // Program 2: taken branch skips an instruction.
    prog = '{addi(1, 0, 100), addi(2, 0, 100), e_b(3'd0, 5'd1, 5'd2, 32'd8), addi(1, 0, 0),
             addi(1, 0, 500), addi(20, 0, 2), HALT};
    start_prog(0, "p2");
    finish_prog("p2");
    chk("p2_x1", dut.u_rf.mem[1], 32'd500);
    chk("p2_x2", dut.u_rf.mem[2], 32'd100);

    // Program 3: byte/half/word loads and stores, plus out-of-range access.
    prog = '{e_u(7'h37, 5'd1, 20'h40001), e_u(7'h37, 5'd2, 20'hDEADC), addi(2, 2, -32'sd273),
             e_s(3'd2, 5'd1, 5'd2, 32'd0),
             e_i(7'h03, 5'd3, 3'd0, 5'd1, 32'd0), e_i(7'h03, 5'd4, 3'd4, 5'd1, 32'd0),
             e_i(7'h03, 5'd5, 3'd1, 5'd1, 32'd0), e_i(7'h03, 5'd6, 3'd5, 5'd1, 32'd2),
             e_i(7'h03, 5'd7, 3'd0, 5'd1, 32'd3), addi(8, 0, 32'h12), e_s(3'd0, 5'd1, 5'd8, 32'd1),
             e_i(7'h03, 5'd9, 3'd2, 5'd1, 32'd0), e_i(7'h03, 5'd10, 3'd2, 5'd1, 32'd1),
             e_s(3'd2, 5'd0, 5'd2, 32'd0), e_i(7'h03, 5'd8, 3'd2, 5'd0, 32'd0), HALT};
    start_prog(0, "p3");
    finish_prog("p3");
    chk("p3_lb",  dut.u_rf.mem[3], 32'hFFFFFFEF);
    chk("p3_lbu", dut.u_rf.mem[4], 32'h000000EF);
    chk("p3_lh",  dut.u_rf.mem[5], 32'hFFFFBEEF);
    chk("p3_lhu", dut.u_rf.mem[6], 32'h0000DEAD);
    chk("p3_lb3", dut.u_rf.mem[7], 32'hFFFFFFDE);
    chk("p3_sb",  dut.u_rf.mem[9], 32'hDEAD12EF);
    chk("p3_lw_misaligned", dut.u_rf.mem[10], 32'hDEAD12EF);
    chk("p3_oob_load", dut.u_rf.mem[8], 32'h0);

    // Program 4: jal/jalr linkage and x0 immutability.
    prog = '{addi(0, 0, 5), e_j(5'd5, 32'd12), addi(6, 0, 7), e_j(5'd0, 32'd12), addi(7, 0, 9),
             e_i(7'h67, 5'd0, 3'd0, 5'd5, 32'd0), HALT};
    start_prog(0, "p4");
    finish_prog("p4");
    chk("p4_link", dut.u_rf.mem[5], 32'h4000_0008);
    chk("p4_x6", dut.u_rf.mem[6], 32'd7);
    chk("p4_x7", dut.u_rf.mem[7], 32'd9);
    chk("p4_x0", dut.u_rf.mem[0], 32'd0);

    // Program 5: shifts, compares, auipc, sub.
    prog = '{addi(1, 0, -32'sd8), e_i(7'h13, 5'd2, 3'd5, 5'd1, 32'h401), e_i(7'h13, 5'd3, 3'd5, 5'd1, 32'd28),
             e_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd4), e_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd5),
             e_u(7'h17, 5'd6, 20'h00001), e_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd7),
             e_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd8), e_r(7'h00, 5'd3, 5'd1, 3'd1, 5'd9),
             e_i(7'h13, 5'd10, 3'd2, 5'd1, -32'sd7), e_i(7'h13, 5'd11, 3'd3, 5'd1, -32'sd1), HALT};
    start_prog(0, "p5");
    finish_prog("p5");
    chk("p5_srai", dut.u_rf.mem[2], 32'hFFFFFFFC);
    chk("p5_srli", dut.u_rf.mem[3], 32'h0000000F);
    chk("p5_slt",  dut.u_rf.mem[4], 32'd1);
    chk("p5_sltu", dut.u_rf.mem[5], 32'd0);
    chk("p5_auipc", dut.u_rf.mem[6], 32'h4000_1014);
    chk("p5_sra",  dut.u_rf.mem[8], 32'hFFFFFFFF);

    // Randomized programs against the interpreter.
    for (int t = 0; t < 6; t++) begin
      gen_random_prog();
      start_prog(1, "rnd");
      finish_prog("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL expose parameter CPU_CLOCK_FREQ, default 50_000_000, core clock frequency in Hz; reserved for the serial block and unused by the core.
REQ-002 SHALL expose port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL expose port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL expose port bp_enable, input, 1 bit, branch-predictor enable; ignored, since this core has no predictor.
REQ-005 SHALL expose port serial_in, input, 1 bit, UART receive line; ignored.
REQ-006 SHALL expose port serial_out, output, 1 bit, UART transmit line; driven constant 1 (idle).
REQ-007 SHALL contain a register-file instance whose storage is an array named mem of 32 x 32-bit words, hierarchically visible to the bench.
REQ-008 SHALL contain a BIOS memory instance whose storage is an array named mem of 4096 x 32-bit words, loadable by the bench via $readmemh before reset release.

Function
REQ-009 SHALL implement RV32I integer instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU operations.
REQ-010 SHALL treat FENCE, SYSTEM (ECALL/EBREAK/CSR) and unknown opcodes as NOPs that advance PC by 4.
REQ-011 SHALL be a multi-cycle FSM with states FETCH, EXEC and MEM.
REQ-012 In FETCH, SHALL present PC to the BIOS memory synchronous read port and go to EXEC.
REQ-013 In EXEC, SHALL decode the read word and read rs1/rs2 combinationally.
REQ-014 In EXEC, non-load instructions SHALL write back rd and update PC at that edge, then go to FETCH.
REQ-015 In EXEC, loads SHALL issue the memory read and go to MEM.
REQ-016 In MEM, SHALL write the extended load data to rd, set PC to PC+4, and go to FETCH.
REQ-017 Latency SHALL be 2 cycles per instruction and 3 cycles per load.
REQ-018 SHALL map the BIOS memory at byte addresses 0x4000_0000-0x4000_3FFF, word index addr[13:2], usable for both instruction fetch and data load/store.
REQ-019 Data accesses outside the BIOS range SHALL read as 0 and SHALL drop writes.
REQ-020 Stores SHALL use per-byte write enables from addr[1:0] and size; SB/SH replicate the data into the addressed lanes.
REQ-021 Loads SHALL select the byte/half by addr[1:0] and sign-extend or zero-extend per funct3; misaligned halfword/word accesses ignore the low bits.
REQ-022 Branch/JAL targets SHALL be PC+imm; JALR target SHALL be (rs1+imm) with bit 0 cleared; JAL/JALR write PC+4 to rd.
REQ-023 Arithmetic SHALL be 32-bit wrap-around; shifts use the low 5 bits of the shift amount; SRA/SRAI arithmetic; SLT signed, SLTU unsigned.
REQ-024 Register x0 SHALL read 0 and writes to it SHALL be discarded (mem[0] stays 0).
REQ-025 When rs equals rd of the same instruction, the old value SHALL be read (for example, add x1,x1,x2 uses the pre-write x1).

Reset
REQ-026 While rst=1 at a rising edge, SHALL set PC=0x4000_0000, state=FETCH and all 32 registers=0; BIOS contents SHALL be preserved.
REQ-027 The first fetch SHALL occur at the first rising edge with rst=0; an asserted rst mid-instruction SHALL abort that instruction with no writeback.
REQ-028 serial_out SHALL be 1 during and after reset.

Verification
REQ-029 addi x1,x0,100; addi x2,x0,200; add x1,x1,x2; addi x20,x0,1 -> x20=1 reached within 100 cycles of reset release and x1=300.
REQ-030 addi x1,x0,100; addi x2,x0,100; beq x1,x2,+8; addi x1,x0,0; addi x1,x0,500; addi x20,x0,2 -> x1=500, x2=100 (skipped instruction has no effect).
REQ-031 sw of 0xDEADBEEF to 0x4000_1000; lb/lbu/lh/lhu at offsets 0-3 -> 0xFFFFFFEF, 0xEF, 0xFFFFBEEF, 0xDEAD as selected; sb 0x12 at offset 1 -> word reads 0xDEAD12EF.
REQ-032 jal x5,+8 at PC P -> x5=P+4, next PC P+8; jalr x0,0(x5) returns to P+4; addi x0,x0,5 leaves x0=0.
REQ-033 addi x1,x0,-8; srai x2,x1,1 -> x2=0xFFFFFFFC; srli x3,x1,28 -> x3=0xF; slt x4,x1,x0 -> x4=1; sltu x5,x1,x0 -> x5=0.
REQ-034 Assert rst for 1 cycle mid-program -> PC restarts at 0x4000_0000, registers read 0, and the program reruns to the same results.
